// File: rtl/dff_checker_if.sv
// dff_checker_if: groups the checker's run handshake, the observed DUT pins
// and the result/statistics outputs. Clock and reset stay outside as plain ports.
interface dff_checker_if #(
    parameter int CW = 8
);
    logic          start;
    logic          d_obs;
    logic          q_obs;
    logic          qbar_obs;
    logic          busy;
    logic          done;
    logic          pass;
    logic [CW-1:0] err_count;
    logic [CW-1:0] sample_count;
    logic [CW-1:0] toggle_count;
    logic [CW-1:0] first_err_idx;

    // Stimulus side: launches runs, drives the observed pins, reads results
    modport master (
        output start, d_obs, q_obs, qbar_obs,
        input  busy, done, pass, err_count, sample_count, toggle_count, first_err_idx
    );

    // Checker side
    modport slave (
        input  start, d_obs, q_obs, qbar_obs,
        output busy, done, pass, err_count, sample_count, toggle_count, first_err_idx
    );
endinterface

// File: rtl/dff_checker.sv
// dff_checker: response checker for a single-bit D flip-flop. Each run primes
// d_prev from d_obs, then makes NUM_SAMPLES comparisons of q_obs against the
// d seen one edge earlier, counting errors (saturating), toggles and the index
// of the first error. Optional build macro DFF_CHECKER_QBAR_CHECK_EN adds the
// qbar_obs == ~q_obs complement check to the mismatch condition.
module dff_checker #(
    parameter int NUM_SAMPLES = 8,
    parameter int CW          = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    dff_checker_if.slave bus
);
    typedef enum logic [1:0] {IDLE, PRIME, CHECK, DONE} state_t;

    localparam logic [CW-1:0] LAST_IDX = CW'(NUM_SAMPLES - 1);
    localparam logic [CW-1:0] ALL_ONES = {CW{1'b1}};

    state_t        state;
    logic          d_prev;
    logic          busy_r;
    logic          done_r;
    logic          pass_r;
    logic [CW-1:0] err_cnt;
    logic [CW-1:0] smp_cnt;
    logic [CW-1:0] tog_cnt;
    logic [CW-1:0] first_idx;
    logic          mismatch;

    // q is compared against the d captured one edge earlier; the complement
    // check is a build option so the port list never changes
`ifdef DFF_CHECKER_QBAR_CHECK_EN
    assign mismatch = (bus.q_obs != d_prev) || (bus.qbar_obs != ~bus.q_obs);
`else
    assign mismatch = (bus.q_obs != d_prev);
`endif

    // Run sequencer with registered status flags and statistics
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            d_prev    <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            pass_r    <= 1'b0;
            err_cnt   <= '0;
            smp_cnt   <= '0;
            tog_cnt   <= '0;
            first_idx <= ALL_ONES;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state     <= PRIME;
                        busy_r    <= 1'b1;
                        done_r    <= 1'b0;
                        pass_r    <= 1'b0;
                        err_cnt   <= '0;
                        smp_cnt   <= '0;
                        tog_cnt   <= '0;
                        first_idx <= ALL_ONES;
                    end
                end
                PRIME: begin
                    d_prev <= bus.d_obs;
                    state  <= CHECK;
                end
                CHECK: begin
                    if (mismatch) begin
                        // err_cnt == 0 identifies the first error even if the
                        // index itself happens to be all-ones-adjacent
                        if (err_cnt == '0)
                            first_idx <= smp_cnt;
                        if (err_cnt != ALL_ONES)
                            err_cnt <= err_cnt + 1'b1;
                    end
                    if (bus.d_obs != d_prev)
                        tog_cnt <= tog_cnt + 1'b1;
                    d_prev  <= bus.d_obs;
                    smp_cnt <= smp_cnt + 1'b1;
                    if (smp_cnt == LAST_IDX) begin
                        state  <= DONE;
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                        // include the final comparison, whose count lands this edge
                        pass_r <= (err_cnt == '0) && !mismatch;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy          = busy_r;
    assign bus.done          = done_r;
    assign bus.pass          = pass_r;
    assign bus.err_count     = err_cnt;
    assign bus.sample_count  = smp_cnt;
    assign bus.toggle_count  = tog_cnt;
    assign bus.first_err_idx = first_idx;
endmodule

// File: tb/tb_dff_checker.sv
// tb_dff_checker: randomized and directed runs against a reference model that
// derives expected statistics from per-cycle d/q/qbar arrays.
module tb_dff_checker;
    localparam int N  = 8;
    localparam int CW = 8;
`ifdef DFF_CHECKER_QBAR_CHECK_EN
    localparam bit QCHK = 1'b1;
`else
    localparam bit QCHK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    dff_checker_if #(.CW(CW)) bus ();
    dff_checker #(.NUM_SAMPLES(N), .CW(CW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

    dff_checker_if #(.CW(2)) sbus ();
    dff_checker #(.NUM_SAMPLES(3), .CW(2)) dut_s (.clk(clk), .rst_n(rst_n), .bus(sbus.slave));

    task automatic check_reset_vals(input string tag);
        n_chk++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL %s busy: got %b want 0", tag, bus.busy); end
        n_chk++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL %s done: got %b want 0", tag, bus.done); end
        n_chk++; if (bus.pass !== 1'b0) begin n_fail++; $display("FAIL %s pass: got %b want 0", tag, bus.pass); end
        n_chk++; if (bus.err_count !== 8'd0) begin n_fail++; $display("FAIL %s err_count: got %0d want 0", tag, bus.err_count); end
        n_chk++; if (bus.sample_count !== 8'd0) begin n_fail++; $display("FAIL %s sample_count: got %0d want 0", tag, bus.sample_count); end
        n_chk++; if (bus.toggle_count !== 8'd0) begin n_fail++; $display("FAIL %s toggle_count: got %0d want 0", tag, bus.toggle_count); end
        n_chk++; if (bus.first_err_idx !== 8'hFF) begin n_fail++; $display("FAIL %s first_err_idx: got %h want ff", tag, bus.first_err_idx); end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        check_reset_vals("reset");
        n_chk++; if (sbus.first_err_idx !== 2'b11) begin n_fail++; $display("FAIL reset small first_err_idx: got %b want 11", sbus.first_err_idx); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // mode 0 ideal/toggle, 1 q stuck 0/toggle, 2 qbar==q ideal/toggle,
    // 3 ideal/random d, 4 random d/q/qbar faults
    task automatic test_run(input int mode, input string tag);
        logic dv [N+1];
        logic qv [N+1];
        logic qbv[N+1];
        int   e_err, e_tog, e_first;
        bit   mm;
        for (int k = 0; k <= N; k++)
            dv[k] = (mode <= 2) ? k[0] : 1'($urandom_range(0, 1));
        qv[0] = 1'b0; qbv[0] = 1'b1;
        for (int k = 1; k <= N; k++) begin
            qv[k]  = (mode == 1) ? 1'b0 : (mode == 4 ? 1'($urandom_range(0, 1)) : dv[k-1]);
            qbv[k] = (mode == 2 || (mode == 4 && $urandom_range(0, 3) == 0)) ? qv[k] : ~qv[k];
        end
        e_err = 0; e_tog = 0; e_first = 255;
        for (int k = 1; k <= N; k++) begin
            mm = (qv[k] != dv[k-1]) || (QCHK && qbv[k] == qv[k]);
            if (mm) begin
                if (e_err == 0) e_first = k - 1;
                if (e_err < 255) e_err++;
            end
            if (dv[k] != dv[k-1]) e_tog++;
        end

        @(negedge clk); bus.start = 1'b1;
        @(negedge clk); bus.start = 1'b0; bus.d_obs = dv[0];
        n_chk++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL %s busy in prime: got %b want 1", tag, bus.busy); end
        for (int k = 1; k <= N; k++) begin
            @(negedge clk);
            bus.d_obs = dv[k]; bus.q_obs = qv[k]; bus.qbar_obs = qbv[k];
            if (k == N) begin
                n_chk++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL %s done early: got %b want 0", tag, bus.done); end
            end
        end
        @(negedge clk);
        n_chk++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL %s done: got %b want 1", tag, bus.done); end
        n_chk++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL %s busy: got %b want 0", tag, bus.busy); end
        n_chk++; if (bus.pass !== (e_err == 0)) begin n_fail++; $display("FAIL %s pass: got %b want %b", tag, bus.pass, e_err == 0); end
        n_chk++; if (bus.err_count !== 8'(e_err)) begin n_fail++; $display("FAIL %s err_count: got %0d want %0d", tag, bus.err_count, e_err); end
        n_chk++; if (bus.sample_count !== 8'(N)) begin n_fail++; $display("FAIL %s sample_count: got %0d want %0d", tag, bus.sample_count, N); end
        n_chk++; if (bus.toggle_count !== 8'(e_tog)) begin n_fail++; $display("FAIL %s toggle_count: got %0d want %0d", tag, bus.toggle_count, e_tog); end
        n_chk++; if (bus.first_err_idx !== 8'(e_first)) begin n_fail++; $display("FAIL %s first_err_idx: got %0d want %0d", tag, bus.first_err_idx, e_first); end
        // results must hold in DONE while start stays low
        repeat (2) @(negedge clk);
        n_chk++; if (bus.done !== 1'b1 || bus.err_count !== 8'(e_err)) begin n_fail++; $display("FAIL %s hold: got done=%b err=%0d want done=1 err=%0d", tag, bus.done, bus.err_count, e_err); end
    endtask

    task automatic test_back_to_back();
        bit exp_done;
        bus.start = 1'b1; bus.d_obs = 1'b0;
        for (int c = 0; c < 3 * (N + 2) + 1; c++) begin
            @(negedge clk);
            bus.q_obs = bus.d_obs; bus.qbar_obs = ~bus.d_obs; bus.d_obs = ~bus.d_obs;
            exp_done = (c >= N + 1) && ((c - (N + 1)) % (N + 2) == 0);
            n_chk++; if (bus.done !== exp_done) begin n_fail++; $display("FAIL b2b done cyc %0d: got %b want %b", c, bus.done, exp_done); end
            n_chk++; if (bus.busy !== !exp_done) begin n_fail++; $display("FAIL b2b busy cyc %0d: got %b want %b", c, bus.busy, !exp_done); end
            if (exp_done) begin
                n_chk++; if (bus.pass !== 1'b1) begin n_fail++; $display("FAIL b2b pass cyc %0d: got %b want 1", c, bus.pass); end
            end
        end
        bus.start = 1'b0;
        repeat (N + 3) @(negedge clk);
    endtask

    task automatic test_reset_midrun();
        @(negedge clk); bus.start = 1'b1;
        @(negedge clk); bus.start = 1'b0; bus.d_obs = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            bus.q_obs = bus.d_obs; bus.qbar_obs = ~bus.d_obs; bus.d_obs = ~bus.d_obs;
        end
        n_chk++; if (bus.sample_count !== 8'd3) begin n_fail++; $display("FAIL midrun sample_count before reset: got %0d want 3", bus.sample_count); end
        @(negedge clk); #2 rst_n = 1'b0; #1;
        check_reset_vals("midrun reset");
        @(negedge clk); rst_n = 1'b1;
        test_run(0, "after reset");
    endtask

    task automatic test_saturation();
        @(negedge clk); sbus.start = 1'b1; sbus.d_obs = 1'b1; sbus.q_obs = 1'b0; sbus.qbar_obs = 1'b1;
        @(negedge clk); sbus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_chk++; if (sbus.toggle_count !== 2'd0) begin n_fail++; $display("FAIL sat toggle after first: got %0d want 0", sbus.toggle_count); end
        n_chk++; if (sbus.err_count !== 2'd1) begin n_fail++; $display("FAIL sat err after first: got %0d want 1", sbus.err_count); end
        @(negedge clk);
        @(negedge clk);
        n_chk++; if (sbus.done !== 1'b1) begin n_fail++; $display("FAIL sat done: got %b want 1", sbus.done); end
        n_chk++; if (sbus.err_count !== 2'd3) begin n_fail++; $display("FAIL sat err_count: got %0d want 3", sbus.err_count); end
        n_chk++; if (sbus.toggle_count !== 2'd0) begin n_fail++; $display("FAIL sat toggle_count: got %0d want 0", sbus.toggle_count); end
        n_chk++; if (sbus.first_err_idx !== 2'd0) begin n_fail++; $display("FAIL sat first_err_idx: got %0d want 0", sbus.first_err_idx); end
        n_chk++; if (sbus.sample_count !== 2'd3) begin n_fail++; $display("FAIL sat sample_count: got %0d want 3", sbus.sample_count); end
        n_chk++; if (sbus.pass !== 1'b0) begin n_fail++; $display("FAIL sat pass: got %b want 0", sbus.pass); end
    endtask

    initial begin
        bus.start = 1'b0; bus.d_obs = 1'b0; bus.q_obs = 1'b0; bus.qbar_obs = 1'b1;
        sbus.start = 1'b0; sbus.d_obs = 1'b0; sbus.q_obs = 1'b0; sbus.qbar_obs = 1'b1;
        test_reset();
        test_run(0, "ideal");
        test_run(1, "q stuck0");
        test_run(2, "qbar eq q");
        for (int i = 0; i < 3; i++) test_run(3, "rand ideal");
        for (int i = 0; i < 5; i++) test_run(4, "rand fault");
        test_back_to_back();
        test_run(0, "after b2b");
        test_reset_midrun();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
